// File: rtl/sine_pkg.sv
// Shared constants and FSM encoding for the sine voice scheduler.
package sine_pkg;

    localparam int          ROM_ADDR_W = 8;
    localparam int          ROM_DATA_W = 16;
    localparam int          SMP_W      = 8;
    localparam logic [7:0]  SMP_MID    = 8'h80;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/sine_voice_sched_phase_bank.sv
// sine_phase_bank: per-voice shadow/active config and phase accumulators.
// Shadow copies to active on i_load; i_step advances the slot's phase.
module sine_phase_bank
    import sine_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_we,
    input  logic [VW-1:0]      i_cfg_voice,
    input  logic [PHASE_W-1:0] i_cfg_inc,
    input  logic               i_cfg_en,
    input  logic               i_cfg_phase_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [VW-1:0]      i_slot,
    output logic [8:0]         o_tbl_idx,
    output logic               o_en
);

    logic [PHASE_W-1:0] r_phase   [NUM_VOICES];
    logic [PHASE_W-1:0] r_inc_sh  [NUM_VOICES];
    logic [PHASE_W-1:0] r_inc_act [NUM_VOICES];
    logic               r_en_sh   [NUM_VOICES];
    logic               r_en_act  [NUM_VOICES];
    logic               r_prst    [NUM_VOICES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v]   <= '0;
                r_inc_sh[v]  <= '0;
                r_inc_act[v] <= '0;
                r_en_sh[v]   <= 1'b0;
                r_en_act[v]  <= 1'b0;
                r_prst[v]    <= 1'b0;
            end
        end else begin
            if (i_load) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    r_inc_act[v] <= r_inc_sh[v];
                    r_en_act[v]  <= r_en_sh[v];
                    if (r_prst[v]) begin
                        r_phase[v] <= '0;
                        r_prst[v]  <= 1'b0;
                    end
                end
            end else if (i_step && r_en_act[i_slot]) begin
                r_phase[i_slot] <= r_phase[i_slot] + r_inc_act[i_slot];
            end
            // Placed last so a write coinciding with a load re-arms the shadow for next frame.
            if (i_cfg_we) begin
                r_inc_sh[i_cfg_voice] <= i_cfg_inc;
                r_en_sh[i_cfg_voice]  <= i_cfg_en;
                r_prst[i_cfg_voice]   <= i_cfg_phase_rst;
            end
        end
    end

    assign o_tbl_idx = r_phase[i_slot][PHASE_W-1 -: 9];
    assign o_en      = r_en_act[i_slot];

endmodule

// File: rtl/sine_voice_sched.sv
// Frame scheduler sharing one sine ROM across NUM_VOICES voices.
// Optional mix accumulator enabled by defining SINE_VOICE_MIX_EN.
//
// state | meaning
// IDLE  | waiting for sample_tick
// ISSUE | one ROM read slot per voice, slot counter walks 0..NUM_VOICES-1
// DRAIN | last voice's sample returns; ticks still rejected
module sine_voice_sched
    import sine_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sample_tick,
    input  logic                  i_cfg_we,
    input  logic [VW-1:0]         i_cfg_voice,
    input  logic [PHASE_W-1:0]    i_cfg_inc,
    input  logic                  i_cfg_en,
    input  logic                  i_cfg_phase_rst,
    output logic                  o_rom_en,
    output logic [ROM_ADDR_W-1:0] o_rom_addr,
    input  logic [ROM_DATA_W-1:0] i_rom_dout,
    output logic                  o_smp_valid,
    output logic [VW-1:0]         o_smp_voice,
    output logic [SMP_W-1:0]      o_smp_data,
    output logic                  o_busy,
    output logic                  o_overrun
`ifdef SINE_VOICE_MIX_EN
    ,
    output logic                      o_mix_valid,
    output logic signed [SMP_W+VW-1:0] o_mix_data
`endif
);

    state_t        r_state;
    logic [VW-1:0] r_slot;
    logic          r_smp_valid;
    logic [VW-1:0] r_smp_voice;
    logic          r_sel;
    logic          r_smp_en;
    logic          w_accept;
    logic          w_issue;
    logic [8:0]    w_tbl_idx;
    logic          w_en;

    assign w_accept = (r_state == IDLE) && i_sample_tick;
    assign w_issue  = (r_state == ISSUE);

    sine_phase_bank #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W)
    ) u_bank (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_cfg_we        (i_cfg_we),
        .i_cfg_voice     (i_cfg_voice),
        .i_cfg_inc       (i_cfg_inc),
        .i_cfg_en        (i_cfg_en),
        .i_cfg_phase_rst (i_cfg_phase_rst),
        .i_load          (w_accept),
        .i_step          (w_issue),
        .i_slot          (r_slot),
        .o_tbl_idx       (w_tbl_idx),
        .o_en            (w_en)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_slot      <= '0;
            r_smp_valid <= 1'b0;
            r_smp_voice <= '0;
            r_sel       <= 1'b0;
            r_smp_en    <= 1'b0;
        end else begin
            r_smp_valid <= w_issue;
            r_smp_voice <= w_issue ? r_slot : '0;
            r_sel       <= w_issue & w_tbl_idx[0];
            r_smp_en    <= w_issue & w_en;
            case (r_state)
                IDLE: begin
                    if (i_sample_tick) begin
                        r_state <= ISSUE;
                        r_slot  <= '0;
                    end
                end
                ISSUE: begin
                    if (r_slot == VW'(NUM_VOICES - 1)) begin
                        r_state <= DRAIN;
                        r_slot  <= '0;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                DRAIN:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = i_sample_tick && o_busy;
    assign o_rom_en    = w_issue && w_en;
    assign o_rom_addr  = o_rom_en ? w_tbl_idx[8:1] : '0;
    assign o_smp_valid = r_smp_valid;
    assign o_smp_voice = r_smp_voice;

    // ROM word holds the even-index sample in its low byte.
    always_comb begin
        o_smp_data = '0;
        if (r_smp_valid) begin
            if (!r_smp_en)  o_smp_data = SMP_MID;
            else if (r_sel) o_smp_data = i_rom_dout[15:8];
            else            o_smp_data = i_rom_dout[7:0];
        end
    end

`ifdef SINE_VOICE_MIX_EN
    localparam int MW = SMP_W + VW;

    logic signed [MW-1:0] r_mix_acc;
    logic                 r_mix_valid;
    logic signed [MW-1:0] r_mix_data;
    logic signed [8:0]    w_delta;
    logic signed [MW-1:0] w_delta_ext;

    assign w_delta     = $signed({1'b0, o_smp_data}) - 9'sd128;
    assign w_delta_ext = MW'(w_delta);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mix_acc   <= '0;
            r_mix_valid <= 1'b0;
            r_mix_data  <= '0;
        end else begin
            r_mix_valid <= (r_state == DRAIN);
            if (w_accept)         r_mix_acc <= '0;
            else if (r_smp_valid) r_mix_acc <= r_mix_acc + w_delta_ext;
            if (r_state == DRAIN) r_mix_data <= r_mix_acc + w_delta_ext;
        end
    end

    assign o_mix_valid = r_mix_valid;
    assign o_mix_data  = r_mix_data;
`endif

endmodule

// File: tb/tb_sine_voice_sched.sv
// Directed bench for sine_voice_sched with a {~addr, addr} ROM model.
module tb_sine_voice_sched;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [23:0] cfg_inc;
    logic        cfg_en;
    logic        cfg_phase_rst;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        smp_valid;
    logic [1:0]  smp_voice;
    logic [7:0]  smp_data;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic       cap_en    [0:7];
    logic [7:0] cap_addr  [0:7];
    logic       cap_valid [0:7];
    logic [1:0] cap_voice [0:7];
    logic [7:0] cap_data  [0:7];
    logic       cap_busy  [0:7];

    typedef struct {
        bit          rst;
        bit          wr;
        int          voice;
        logic [23:0] inc;
        bit          en;
        int          chk_voice;
        bit          exp_en;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [7];

    sine_voice_sched #(.NUM_VOICES(4), .PHASE_W(24)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_sample_tick   (sample_tick),
        .i_cfg_we        (cfg_we),
        .i_cfg_voice     (cfg_voice),
        .i_cfg_inc       (cfg_inc),
        .i_cfg_en        (cfg_en),
        .i_cfg_phase_rst (cfg_phase_rst),
        .o_rom_en        (rom_en),
        .o_rom_addr      (rom_addr),
        .i_rom_dout      (rom_dout),
        .o_smp_valid     (smp_valid),
        .o_smp_voice     (smp_voice),
        .o_smp_data      (smp_data),
        .o_busy          (busy),
        .o_overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rom_dout = 16'h0000;
    always @(posedge clk) if (rom_en) rom_dout <= {~rom_addr, rom_addr};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_cfg(input int v, input logic [23:0] inc, input bit en, input bit prst);
        cfg_voice = v[1:0]; cfg_inc = inc; cfg_en = en; cfg_phase_rst = prst;
    endtask

    task automatic cfg_write(input int v, input logic [23:0] inc, input bit en, input bit prst);
        @(negedge clk);
        set_cfg(v, inc, en, prst);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Tick in cycle 0; capture cycles 1..6; optional cfg_we pulse in cycle wr_cyc.
    task automatic run_frame(input int wr_cyc);
        @(negedge clk);
        sample_tick = 1'b1;
        cfg_we = (wr_cyc == 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            cfg_we = (wr_cyc == c);
            #1;
            cap_en[c]    = rom_en;
            cap_addr[c]  = rom_addr;
            cap_valid[c] = smp_valid;
            cap_voice[c] = smp_voice;
            cap_data[c]  = smp_data;
            cap_busy[c]  = busy;
        end
        cfg_we = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int k, input bit en,
                              input logic [7:0] addr, input logic [7:0] data);
        chk($sformatf("%s rom_en s%0d", tag, k), 32'(cap_en[k+1]), 32'(en));
        if (en) chk($sformatf("%s rom_addr s%0d", tag, k), 32'(cap_addr[k+1]), 32'(addr));
        chk($sformatf("%s smp_valid s%0d", tag, k), 32'(cap_valid[k+2]), 32'd1);
        chk($sformatf("%s smp_voice s%0d", tag, k), 32'(cap_voice[k+2]), 32'(k));
        chk($sformatf("%s smp_data s%0d", tag, k), 32'(cap_data[k+2]), 32'(data));
    endtask

    task automatic check_common(input string tag);
        for (int c = 1; c <= 6; c++)
            chk($sformatf("%s busy c%0d", tag, c), 32'(cap_busy[c]), (c <= 5) ? 32'd1 : 32'd0);
        chk({tag, " valid c1"}, 32'(cap_valid[1]), 32'd0);
        chk({tag, " data c1"}, 32'(cap_data[1]), 32'd0);
        chk({tag, " valid c6"}, 32'(cap_valid[6]), 32'd0);
    endtask

    initial begin
        int nsmp;
        rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
        set_cfg(0, 24'h0, 1'b0, 1'b0);

        vecs[0] = '{1, 0, 0, 24'h000000, 0, 0, 0, 8'h00, 8'h80};
        vecs[1] = '{0, 1, 0, 24'h008000, 1, 0, 1, 8'h00, 8'h00};
        vecs[2] = '{0, 0, 0, 24'h000000, 0, 0, 1, 8'h00, 8'hFF};
        vecs[3] = '{0, 0, 0, 24'h000000, 0, 0, 1, 8'h01, 8'h01};
        vecs[4] = '{1, 1, 2, 24'hFF8000, 1, 2, 1, 8'h00, 8'h00};
        vecs[5] = '{0, 0, 0, 24'h000000, 0, 2, 1, 8'hFF, 8'h00};
        vecs[6] = '{0, 0, 0, 24'h000000, 0, 2, 1, 8'hFF, 8'hFF};

        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset smp_valid", 32'(smp_valid), 32'd0);
        chk("reset rom_en", 32'(rom_en), 32'd0);
        chk("reset smp_data", 32'(smp_data), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);

        // Single-voice frames plus the all-disabled frame.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].wr) cfg_write(vecs[i].voice, vecs[i].inc, vecs[i].en, 1'b0);
            run_frame(-1);
            for (int k = 0; k < 4; k++) begin
                if (k == vecs[i].chk_voice)
                    check_slot($sformatf("vec%0d", i), k, vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_data);
                else
                    check_slot($sformatf("vec%0d", i), k, 1'b0, 8'h00, 8'h80);
            end
            check_common($sformatf("vec%0d", i));
        end

        // Ticks while busy, including one in DRAIN, are dropped.
        do_reset();
        nsmp = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            sample_tick = (c == 2 || c == 5);
            #1;
            if (smp_valid) nsmp++;
            if (c == 2 || c == 5) chk($sformatf("overrun c%0d", c), 32'(overrun), 32'd1);
            if (c == 3) chk("overrun idle c3", 32'(overrun), 32'd0);
            if (c == 7) chk("no second frame busy", 32'(busy), 32'd0);
        end
        sample_tick = 1'b0;
        chk("overrun frame sample count", 32'(nsmp), 32'd4);

        // Mid-frame and tick-cycle config writes land in the following frame.
        do_reset();
        cfg_write(1, 24'h020000, 1'b1, 1'b0);
        run_frame(-1);
        check_slot("cfgA", 1, 1'b1, 8'h00, 8'h00);
        set_cfg(1, 24'h010000, 1'b1, 1'b0);
        run_frame(1);
        check_slot("cfgB", 1, 1'b1, 8'h02, 8'h02);
        run_frame(-1);
        check_slot("cfgC", 1, 1'b1, 8'h04, 8'h04);
        set_cfg(1, 24'h010000, 1'b1, 1'b1);
        run_frame(0);
        check_slot("cfgD", 1, 1'b1, 8'h05, 8'h05);
        set_cfg(1, 24'h010000, 1'b1, 1'b0);
        run_frame(-1);
        check_slot("prstE", 1, 1'b1, 8'h00, 8'h00);
        run_frame(-1);
        check_slot("prstF", 1, 1'b1, 8'h01, 8'h01);

        // Async reset during slot 2.
        do_reset();
        cfg_write(0, 24'h010000, 1'b1, 1'b0);
        cfg_write(2, 24'h010000, 1'b1, 1'b0);
        run_frame(-1);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre-reset rom_en s2", 32'(rom_en), 32'd1);
        chk("pre-reset rom_addr s2", 32'(rom_addr), 32'h01);
        chk("pre-reset smp_valid", 32'(smp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst smp_valid", 32'(smp_valid), 32'd0);
        chk("rst rom_en", 32'(rom_en), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-rst valid c%0d", c), 32'(smp_valid), 32'd0);
            chk($sformatf("post-rst busy c%0d", c), 32'(busy), 32'd0);
        end
        cfg_write(0, 24'h010000, 1'b1, 1'b0);
        run_frame(-1);
        check_slot("restart", 0, 1'b1, 8'h00, 8'h00);
        check_slot("restart", 2, 1'b0, 8'h00, 8'h80);
        check_common("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
